// File: rtl/demux_memoria_valid.sv
// Registered 1-to-2 demux placed after the 2x1 mux-with-memory; routes each valid word to lane 0 or 1.
// Optional per-lane saturating word counters (cnt0/cnt1) are enabled by defining DEMUX_CNT_EN.
module demux_memoria_valid #(
  parameter int BW = 2
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [BW-1:0] data_in,
  input  logic          valid_in,
  input  logic          auto_sel,
  input  logic          selector,
  output logic [BW-1:0] data_out0,
  output logic [BW-1:0] data_out1,
  output logic          valid_out0,
  output logic          valid_out1,
  output logic          next_lane
`ifdef DEMUX_CNT_EN
  ,
  output logic [7:0]    cnt0,
  output logic [7:0]    cnt1
`endif
);

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  lane_e state, state_nxt;
  logic  lane;
  logic  wr0, wr1;

  always_ff @(posedge clk) begin
    if (!reset_L) state <= LANE0;
    else          state <= state_nxt;
  end

  // Next state always points at the lane opposite to the one just used, in either mode.
  always_comb begin
    state_nxt = state;
    wr0       = 1'b0;
    wr1       = 1'b0;
    lane      = auto_sel ? (state == LANE1) : selector;
    if (valid_in) begin
      state_nxt = lane ? LANE0 : LANE1;
      wr0       = ~lane;
      wr1       = lane;
    end
  end

  assign next_lane = (state == LANE1);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_out0  <= '0;
      data_out1  <= '0;
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
    end else begin
      valid_out0 <= wr0;
      valid_out1 <= wr1;
      if (wr0) data_out0 <= data_in;
      if (wr1) data_out1 <= data_in;
    end
  end

`ifdef DEMUX_CNT_EN
  // Counters stop at 255 rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt0 <= 8'd0;
      cnt1 <= 8'd0;
    end else begin
      if (wr0 && (cnt0 != 8'hFF)) cnt0 <= cnt0 + 8'd1;
      if (wr1 && (cnt1 != 8'hFF)) cnt1 <= cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_memoria_valid.sv
// Scoreboard bench for demux_memoria_valid: stimulus pushes hand-computed expectations, monitor pops and compares.
// Counter checks are compiled in only when DEMUX_CNT_EN is defined.
module tb_demux_memoria_valid;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       valid_in = 1'b0;
  logic       auto_sel = 1'b1;
  logic       selector = 1'b0;
  logic [1:0] data_out0, data_out1;
  logic       valid_out0, valid_out1, next_lane;
`ifdef DEMUX_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [1:0] d0;
    logic [1:0] d1;
    logic       v0;
    logic       v1;
    logic       nl;
    logic       chk_cnt;
    logic [7:0] c0;
    logic [7:0] c1;
  } exp_t;

  exp_t sb[$];

  demux_memoria_valid #(.BW(2)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .auto_sel  (auto_sel),
    .selector  (selector),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .valid_out0(valid_out0),
    .valid_out1(valid_out1),
    .next_lane (next_lane)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and queue what the outputs must show after the next rising edge.
  task automatic applyStimulus(input string name, input logic rst_l, input logic [1:0] din,
                               input logic vin, input logic aut, input logic sel,
                               input logic [1:0] ed0, input logic [1:0] ed1,
                               input logic ev0, input logic ev1, input logic enl,
                               input logic cc = 1'b0, input logic [7:0] ec0 = 8'd0,
                               input logic [7:0] ec1 = 8'd0);
    exp_t e;
    @(negedge clk);
    reset_L  = rst_l;
    data_in  = din;
    valid_in = vin;
    auto_sel = aut;
    selector = sel;
    e.name = name; e.d0 = ed0; e.d1 = ed1; e.v0 = ev0; e.v1 = ev1; e.nl = enl;
    e.chk_cnt = cc; e.c0 = ec0; e.c1 = ec1;
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents registered outputs every cycle, so compare one entry per edge while any are queued.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.name, ".data_out0"}, 8'(data_out0), 8'(e.d0));
      checkOutput({e.name, ".data_out1"}, 8'(data_out1), 8'(e.d1));
      checkOutput({e.name, ".valid_out0"}, 8'(valid_out0), 8'(e.v0));
      checkOutput({e.name, ".valid_out1"}, 8'(valid_out1), 8'(e.v1));
      checkOutput({e.name, ".next_lane"}, 8'(next_lane), 8'(e.nl));
`ifdef DEMUX_CNT_EN
      if (e.chk_cnt) begin
        checkOutput({e.name, ".cnt0"}, cnt0, e.c0);
        checkOutput({e.name, ".cnt1"}, cnt1, e.c1);
      end
`endif
    end
  end

  initial begin
    //             name        rst din   vin aut sel  d0     d1     v0 v1 nl
    applyStimulus("reset_a",   0, 2'b11, 1, 1, 0,   2'b00, 2'b00, 0, 0, 0);
    applyStimulus("reset_b",   0, 2'b11, 1, 1, 0,   2'b00, 2'b00, 0, 0, 0);

    applyStimulus("auto_1",    1, 2'b01, 1, 1, 0,   2'b01, 2'b00, 1, 0, 1);
    applyStimulus("auto_2",    1, 2'b10, 1, 1, 0,   2'b01, 2'b10, 0, 1, 0);
    applyStimulus("auto_3",    1, 2'b11, 1, 1, 0,   2'b11, 2'b10, 1, 0, 1);
    applyStimulus("auto_4",    1, 2'b00, 1, 1, 0,   2'b11, 2'b00, 0, 1, 0);

    applyStimulus("bubble_1",  1, 2'b01, 1, 1, 0,   2'b01, 2'b00, 1, 0, 1);
    applyStimulus("bubble_2",  1, 2'b11, 0, 1, 0,   2'b01, 2'b00, 0, 0, 1);
    applyStimulus("bubble_3",  1, 2'b10, 1, 1, 0,   2'b01, 2'b10, 0, 1, 0);

    applyStimulus("manual_1",  1, 2'b11, 1, 0, 1,   2'b01, 2'b11, 0, 1, 0);
    applyStimulus("then_auto", 1, 2'b01, 1, 1, 1,   2'b01, 2'b11, 1, 0, 1);
    applyStimulus("sel_ignor", 1, 2'b10, 1, 1, 0,   2'b01, 2'b10, 0, 1, 0);
    applyStimulus("manual_0a", 1, 2'b11, 1, 0, 0,   2'b11, 2'b10, 1, 0, 1);
    applyStimulus("manual_0b", 1, 2'b00, 1, 0, 0,   2'b00, 2'b10, 1, 0, 1);
    applyStimulus("auto_cont", 1, 2'b01, 1, 1, 0,   2'b00, 2'b01, 0, 1, 0);

    applyStimulus("pre_rst_0", 1, 2'b10, 1, 1, 0,   2'b10, 2'b01, 1, 0, 1);
    applyStimulus("pre_rst_1", 1, 2'b01, 1, 1, 0,   2'b10, 2'b01, 0, 1, 0);
    applyStimulus("mid_reset", 0, 2'b10, 1, 1, 0,   2'b00, 2'b00, 0, 0, 0);
    applyStimulus("post_rst",  1, 2'b11, 1, 1, 0,   2'b11, 2'b00, 1, 0, 1);
    applyStimulus("rst_lane1", 0, 2'b01, 1, 1, 1,   2'b00, 2'b00, 0, 0, 0);
    applyStimulus("after_rst", 1, 2'b10, 1, 1, 1,   2'b10, 2'b00, 1, 0, 1);

`ifdef DEMUX_CNT_EN
    applyStimulus("cnt_rst",   0, 2'b00, 0, 0, 0,   2'b00, 2'b00, 0, 0, 0, 1, 8'd0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus("cnt_sat", 1, 2'(i), 1, 0, 0, 2'(i), 2'b00, 1, 0, 1,
                    1, (i >= 254) ? 8'd255 : 8'(i + 1), 8'd0);
    end
    applyStimulus("cnt_clr",   0, 2'b11, 1, 0, 0,   2'b00, 2'b00, 0, 0, 0, 1, 8'd0, 8'd0);
`endif

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    #2;
    checkOutput("scoreboard_drain", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_memoria_valid.md
Name: demux_memoria_valid

Overview:
- Registered 1-to-2 demultiplexer that sits directly downstream of the 2x1 mux-with-memory stage.
- Takes the mux's single data stream plus valid, and routes each valid word to one of two output lanes.
- Lane choice is either alternating round-robin (auto mode) or an external selector (manual mode).
- Each lane holds its last word when nothing is written to it, mirroring the memory behaviour of the upstream mux.

Parameters:
- BW, 2, data width of input and both output lanes (must be >= 1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  synchronous active-low reset, sampled on posedge clk.
- data_in  input  BW  word from upstream mux (its data_out).
- valid_in  input  1  high when data_in carries a word (upstream valid_output).
- auto_sel  input  1  1 = round-robin lane selection; 0 = lane taken from selector.
- selector  input  1  lane for the current word in manual mode (0 = lane 0, 1 = lane 1); ignored when auto_sel=1.
- data_out0  output  BW  lane 0 registered data.
- data_out1  output  BW  lane 1 registered data.
- valid_out0  output  1  lane 0 received a word this cycle.
- valid_out1  output  1  lane 1 received a word this cycle.
- next_lane  output  1  FSM state: lane that the next auto-mode word will take.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on reset_L. No asynchronous paths.
- Reset, when reset_L=0 at posedge:
  - data_out0 = 0, data_out1 = 0, valid_out0 = 0, valid_out1 = 0.
  - next_lane = 0 (state LANE0).
  - Reset dominates valid_in; a word presented during a reset cycle is dropped.
- Lane FSM: two states, LANE0 (next_lane=0) and LANE1 (next_lane=1).
- Lane for the current word:
  - auto_sel=1: lane = next_lane.
  - auto_sel=0: lane = selector.
- Accepted word (reset_L=1, valid_in=1 at posedge):
  - data_out<lane> <= data_in; valid_out<lane> <= 1; the other lane's valid_out <= 0 and its data holds.
  - next_lane <= ~lane, in both modes. Switching manual to auto therefore continues alternation from the last lane used.
- No word (reset_L=1, valid_in=0 at posedge):
  - valid_out0 <= 0, valid_out1 <= 0.
  - Both data_out hold their value (memory); next_lane holds.
- Latency: exactly one clock. A word sampled at edge N is visible on its lane after edge N, with valid high for exactly that one cycle.
- Valid signals: valid_out0 and valid_out1 are never both 1 in the same cycle.
- No backpressure: every valid word is accepted; no ready signal.
- Width: data passes unmodified, no truncation or extension; BW=1 must work.
- mode change: auto_sel or selector may change every cycle; only the values sampled at the posedge matter.
- Reset mid-stream: all outputs clear on the next edge, FSM returns to LANE0, and the first word after reset goes to lane 0 in auto mode.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Adds output ports cnt0 and cnt1, each 8 bits.
  - Each counts the accepted words routed to its lane.
  - Counters saturate at 255 (no wrap) and are cleared to 0 by reset.
  - Counter update is in the same edge as the data write.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with valid_in=1, data_in=2'b11 -> data_out0/1=00, valid_out0/1=0, next_lane=0 throughout.
- Auto alternation (BW=2, auto_sel=1): data_in 01, 10, 11, 00 on consecutive cycles with valid_in=1 ->
  - cycle+1: lane0=01, valid_out0=1.
  - cycle+2: lane1=10, valid_out1=1.
  - cycle+3: lane0=11.
  - cycle+4: lane1=00.
  - next_lane toggles each cycle.
- Bubble (auto): sequence 01 (valid=1), 11 (valid=0), 10 (valid=1) ->
  - lane0=01.
  - Bubble cycle: both valid_out=0, lane0 holds 01, next_lane stays 1.
  - Then lane1=10.
- Manual then auto: auto_sel=0, selector=1, data 11 -> lane1=11, valid_out1=1, next_lane=0; then auto_sel=1, data 01 -> lane0=01.
- Reset mid-stream: after lane0=10 and lane1=01, reset_L=0 one cycle -> all data/valid=0, next_lane=0; next word 11 in auto -> lane0=11.
- DEMUX_CNT_EN: manual selector=0, 300 consecutive valid words -> cnt0=255 (held, no wrap), cnt1=0; then reset -> cnt0=0.
